spi_reg_bank: RTL

Register bank for the APB-to-SPI bridge, sitting directly downstream of the APB bus decoder. It consumes the decoder's 12-bit offset, write/read strobes and write data, and returns read data and an error flag. It holds the SPI control and clock-divider registers, 4-deep TX/RX byte FIFOs and sticky interrupt flags. It presents a valid/ready byte stream to the SPI shift engine.

---
 rtl/spi_reg_pkg.sv | 70 +++++++
 rtl/spi_sync_fifo.sv | 75 +++++++
 rtl/spi_reg_bank.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// ----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the APB-to-SPI register bank: register byte offsets,
// bit positions inside CTRL / STATUS / INTSTAT, and an address decoder helper
// that maps a decoder offset onto a register select.
// ----------------------------------------------------------------------------
package spi_reg_pkg;

    // Register byte offsets
    localparam logic [11:0] ADDR_CTRL    = 12'h000;
    localparam logic [11:0] ADDR_STATUS  = 12'h004;
    localparam logic [11:0] ADDR_CLKDIV  = 12'h008;
    localparam logic [11:0] ADDR_TXDATA  = 12'h00C;
    localparam logic [11:0] ADDR_RXDATA  = 12'h010;
    localparam logic [11:0] ADDR_INTSTAT = 12'h014;
    localparam logic [11:0] REG_LAST     = 12'h014;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_CPHA   = 2;
    localparam int CTRL_IE_LSB = 4;
    // Bit 3 is unimplemented and always reads 0
    localparam logic [7:0] CTRL_WMASK = 8'hF7;

    // STATUS bit positions
    localparam int STAT_TX_EMPTY  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_FULL   = 3;
    localparam int STAT_BUSY      = 4;
    localparam int STAT_TXCNT_LSB = 8;
    localparam int STAT_RXCNT_LSB = 12;

    // INTSTAT bit positions (same order as the CTRL IE mask)
    localparam int INT_TXE   = 0;
    localparam int INT_RXNE  = 1;
    localparam int INT_RXOVF = 2;
    localparam int INT_TXOVF = 3;
    localparam int INT_W     = 4;

    typedef enum logic [2:0] {
        SEL_CTRL    = 3'd0,
        SEL_STATUS  = 3'd1,
        SEL_CLKDIV  = 3'd2,
        SEL_TXDATA  = 3'd3,
        SEL_RXDATA  = 3'd4,
        SEL_INTSTAT = 3'd5,
        SEL_NONE    = 3'd7
    } reg_sel_e;

    // Misaligned or out-of-range offsets decode to SEL_NONE
    function automatic reg_sel_e decode_reg(input logic [11:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00 && addr <= REG_LAST) begin
            case (addr[4:2])
                3'd0:    sel = SEL_CTRL;
                3'd1:    sel = SEL_STATUS;
                3'd2:    sel = SEL_CLKDIV;
                3'd3:    sel = SEL_TXDATA;
                3'd4:    sel = SEL_RXDATA;
                3'd5:    sel = SEL_INTSTAT;
                default: sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// ----------------------------------------------------------------------------
// spi_sync_fifo
// Single-clock show-ahead FIFO. The head entry is always presented on o_dout.
// A push while full is rejected (even with a simultaneous pop); a pop while
// empty is ignored. i_flush empties the FIFO and zeroes both pointers.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write request and data
//   i_pop            read request (advances head)
//   i_flush          discard all contents
//   o_dout           head entry
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop  & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    // Storage is not reset; only the pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/spi_reg_bank.sv
// ----------------------------------------------------------------------------
// spi_reg_bank
// Register bank of the APB-to-SPI bridge. Decodes the bus decoder's offset and
// strobes, holds CTRL / CLKDIV, TX and RX byte FIFOs and sticky interrupt
// flags, and feeds the SPI shift engine through a valid/ready byte stream.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_addr, i_wr_en, i_rd_en   decoder offset and one-cycle access strobes
//   i_wdata / o_rdata          write data / combinational read data
//   o_error                    combinational access error
//   o_spi_en, o_cpol, o_cpha   CTRL fields
//   o_clkdiv                   SCLK divider
//   o_tx_data, o_tx_valid, i_tx_ready   TX byte stream to the engine
//   i_rx_data, i_rx_valid      received bytes from the engine
//   i_busy                     engine shifting indicator
//   o_irq                      level interrupt
// ----------------------------------------------------------------------------
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] CLKDIV_RST = 16'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_addr,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_error,
    output logic        o_spi_en,
    output logic        o_cpol,
    output logic        o_cpha,
    output logic [15:0] o_clkdiv,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_busy,
    output logic        o_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        r_ctrl;
    logic [15:0]       r_clkdiv;
    logic [INT_W-1:0]  r_intstat;
    logic [INT_W-1:0]  w_intstat_next;
    logic [INT_W-1:0]  w_int_set;
    logic [INT_W-1:0]  w_int_clr;

    reg_sel_e          w_sel;
    logic              w_error;
    logic              w_wr_ok;
    logic              w_rd_ok;

    logic              w_tx_push, w_tx_pop, w_tx_flush;
    logic              w_tx_full, w_tx_empty;
    logic [CW-1:0]     w_tx_count;
    logic [7:0]        w_tx_dout;

    logic              w_rx_pop;
    logic              w_rx_full, w_rx_empty;
    logic [CW-1:0]     w_rx_count;
    logic [7:0]        w_rx_dout;

    logic [31:0]       w_status;

    // ------------------------------------------------------------------
    // Access decode and error qualification
    // ------------------------------------------------------------------
    assign w_sel = decode_reg(i_addr);

    always_comb begin
        w_error = 1'b0;
        if (w_sel == SEL_NONE)
            w_error = 1'b1;
        if (i_wr_en && (w_sel == SEL_STATUS || w_sel == SEL_RXDATA))
            w_error = 1'b1;
        if (i_wr_en && w_sel == SEL_TXDATA && w_tx_full)
            w_error = 1'b1;
        if (i_rd_en && w_sel == SEL_RXDATA && w_rx_empty)
            w_error = 1'b1;
        w_error = w_error & (i_wr_en | i_rd_en);
    end

    assign o_error = w_error;
    assign w_wr_ok = i_wr_en & ~w_error;
    assign w_rd_ok = i_rd_en & ~w_error;

    // ------------------------------------------------------------------
    // CTRL / CLKDIV
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl   <= '0;
            r_clkdiv <= CLKDIV_RST;
        end else if (w_wr_ok) begin
            if (w_sel == SEL_CTRL)   r_ctrl   <= i_wdata[7:0] & CTRL_WMASK;
            if (w_sel == SEL_CLKDIV) r_clkdiv <= i_wdata[15:0];
        end
    end

    assign o_spi_en = r_ctrl[CTRL_EN];
    assign o_cpol   = r_ctrl[CTRL_CPOL];
    assign o_cpha   = r_ctrl[CTRL_CPHA];
    assign o_clkdiv = r_clkdiv;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    assign w_tx_push  = w_wr_ok & (w_sel == SEL_TXDATA);
    assign o_tx_valid = ~w_tx_empty & r_ctrl[CTRL_EN];
    assign w_tx_pop   = o_tx_valid & i_tx_ready;
    // Disabling the bridge discards any pending TX bytes
    assign w_tx_flush = w_wr_ok & (w_sel == SEL_CTRL) & r_ctrl[CTRL_EN] & ~i_wdata[CTRL_EN];
    assign o_tx_data  = w_tx_dout;

    assign w_rx_pop   = w_rd_ok & (w_sel == SEL_RXDATA);

    spi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .i_din   (i_wdata[7:0]),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    spi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_rx_valid),
        .i_pop   (w_rx_pop),
        .i_flush (1'b0),
        .i_din   (i_rx_data),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // ------------------------------------------------------------------
    // Sticky interrupt flags
    // ------------------------------------------------------------------
    // TXE: last byte leaves without a refill, or a flush empties a non-empty FIFO
    assign w_int_set[INT_TXE]   = (w_tx_pop & (w_tx_count == CW'(1)) & ~w_tx_push)
                                | (w_tx_flush & ~w_tx_empty);
    assign w_int_set[INT_RXNE]  = i_rx_valid & w_rx_empty;
    assign w_int_set[INT_RXOVF] = i_rx_valid & w_rx_full;
    // TXOVF is raised even though the access itself is flagged as an error
    assign w_int_set[INT_TXOVF] = i_wr_en & (w_sel == SEL_TXDATA) & w_tx_full;

    assign w_int_clr = (w_wr_ok && w_sel == SEL_INTSTAT) ? i_wdata[INT_W-1:0] : '0;

    // Set has priority over a same-cycle write-1-to-clear
    generate
        for (genvar gi = 0; gi < INT_W; gi++) begin : g_intstat
            assign w_intstat_next[gi] = w_int_set[gi] | (r_intstat[gi] & ~w_int_clr[gi]);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_intstat <= '0;
        else          r_intstat <= w_intstat_next;
    end

    assign o_irq = |(r_intstat & r_ctrl[CTRL_IE_LSB +: INT_W]);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_status = '0;
        w_status[STAT_TX_EMPTY] = w_tx_empty;
        w_status[STAT_TX_FULL]  = w_tx_full;
        w_status[STAT_RX_EMPTY] = w_rx_empty;
        w_status[STAT_RX_FULL]  = w_rx_full;
        w_status[STAT_BUSY]     = i_busy;
        w_status[STAT_TXCNT_LSB +: 3] = 3'(w_tx_count);
        w_status[STAT_RXCNT_LSB +: 3] = 3'(w_rx_count);
    end

    always_comb begin
        o_rdata = '0;
        if (w_rd_ok) begin
            case (w_sel)
                SEL_CTRL:    o_rdata = {24'b0, r_ctrl};
                SEL_STATUS:  o_rdata = w_status;
                SEL_CLKDIV:  o_rdata = {16'b0, r_clkdiv};
                SEL_RXDATA:  o_rdata = {24'b0, w_rx_dout};
                SEL_INTSTAT: o_rdata = {{(32-INT_W){1'b0}}, r_intstat};
                default:     o_rdata = '0;
            endcase
        end
    end

    // Upper write-data bits have no destination
    logic w_unused;
    assign w_unused = ^i_wdata[31:16];

endmodule
